// File: rtl/datapath_control_sequencer.sv
// Moore control sequencer for the single-bus datapath: fetch (T0-T2), decode (T3), ALU / MUL-DIV execute (T4-T6).
// Build macro SEQ_SINGLE_STEP_EN adds a step input and a HOLD state entered at every instruction end.
module datapath_control_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int OPW         = 5
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           run,
  input  logic           mem_ack,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic           step,
`endif
  input  logic [31:0]    ir,
  output logic           PCout,
  output logic           ZLowout,
  output logic           ZHighout,
  output logic           MDRout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           IncPC,
  output logic           Read,
  output logic           ZLowIn,
  output logic           ZHighIn,
  output logic           HIin,
  output logic           LOin,
  output logic [15:0]    r_out,
  output logic [15:0]    r_in,
  output logic [OPW-1:0] operation,
  output logic           busy,
  output logic           instr_done,
  output logic           mem_err,
  output logic           illegal_op
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [4:0] OP_ALU_LO = 5'h03;
  localparam logic [4:0] OP_ALU_HI = 5'h0C;
  localparam logic [4:0] OP_MUL    = 5'h0F;
  localparam logic [4:0] OP_DIV    = 5'h10;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7
`ifdef SEQ_SINGLE_STEP_EN
    ,
    S_HOLD = 4'd8
`endif
  } state_t;

  state_t        state_q, state_d, end_state;
  logic [CW-1:0] cnt_q;
  logic          timeout_hit;

  // Decoded fields are captured at the end of T3 so T4-T6 no longer depend on ir.
  logic [4:0]    op_q;
  logic          md_q;
  logic [3:0]    ra_q, rb_q, rc_q;

  logic [4:0]    op_ir;
  logic [3:0]    ra_ir, rb_ir, rc_ir;
  logic          is_alu_ir, is_md_ir;
  logic          unused_ir;

  assign op_ir     = ir[31:27];
  assign ra_ir     = ir[26:23];
  assign rb_ir     = ir[22:19];
  assign rc_ir     = ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign is_alu_ir = (op_ir >= OP_ALU_LO) && (op_ir <= OP_ALU_HI);
  assign is_md_ir  = (op_ir == OP_MUL) || (op_ir == OP_DIV);

  // A missing ack on the last allowed T1 cycle aborts the fetch; an ack that same cycle wins.
  assign timeout_hit = (state_q == S_T1) && !mem_ack && (cnt_q == CW'(MEM_TIMEOUT - 1));

`ifdef SEQ_SINGLE_STEP_EN
  assign end_state = S_HOLD;
`else
  assign end_state = run ? S_T0 : S_IDLE;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mem_err <= 1'b0;
      op_q    <= '0;
      md_q    <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_T1 && !mem_ack && !timeout_hit) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      if (timeout_hit) begin
        mem_err <= 1'b1;
      end
      if (state_q == S_T3) begin
        op_q <= op_ir;
        md_q <= is_md_ir;
        ra_q <= ra_ir;
        rb_q <= rb_ir;
        rc_q <= rc_ir;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (mem_ack) begin
          state_d = S_T2;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_T2:   state_d = S_T3;
      S_T3:   state_d = (is_alu_ir || is_md_ir) ? S_T4 : end_state;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = md_q ? S_T6 : end_state;
      S_T6:   state_d = end_state;
`ifdef SEQ_SINGLE_STEP_EN
      S_HOLD: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (step) begin
          state_d = S_T0;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode from state; T3 also reads ir, which is the IR register loaded in T2.
  always_comb begin
    // NOTE: every output is defaulted first so no branch of the case can infer a latch.
    PCout      = 1'b0;
    ZLowout    = 1'b0;
    ZHighout   = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    ZLowIn     = 1'b0;
    ZHighIn    = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    r_out      = '0;
    r_in       = '0;
    operation  = '0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (is_alu_ir) begin
          r_out = 16'd1 << rb_ir;
          Yin   = 1'b1;
        end else if (is_md_ir) begin
          r_out = 16'd1 << ra_ir;
          Yin   = 1'b1;
        end else begin
          illegal_op = 1'b1;
        end
      end
      S_T4: begin
        operation = OPW'(op_q);
        ZLowIn    = 1'b1;
        ZHighIn   = 1'b1;
        r_out     = 16'd1 << (md_q ? rb_q : rc_q);
      end
      S_T5: begin
        ZLowout = 1'b1;
        if (md_q) begin
          LOin = 1'b1;
        end else begin
          // R0 is never a write target; the result is dropped but the instruction still retires.
          if (ra_q != 4'd0) r_in = 16'd1 << ra_q;
          instr_done = 1'b1;
        end
      end
      S_T6: begin
        ZHighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_datapath_control_sequencer.sv
// Self-checking bench for datapath_control_sequencer: instruction-level model builds per-cycle expected strobes.
module tb_datapath_control_sequencer;

  localparam int MEM_TIMEOUT = 15;
  localparam int OPW         = 5;

  logic           clk, clr, run, mem_ack;
  logic [31:0]    ir, ir_next;
  logic           PCout, ZLowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic           ZLowIn, ZHighIn, HIin, LOin, busy, instr_done, mem_err, illegal_op;
  logic [15:0]    r_out, r_in;
  logic [OPW-1:0] operation;
`ifdef SEQ_SINGLE_STEP_EN
  logic           step;
`endif

  typedef struct packed {
    logic PCout, ZLowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
    logic ZLowIn, ZHighIn, HIin, LOin;
    logic [15:0] r_out;
    logic [15:0] r_in;
    logic [4:0]  operation;
    logic busy, instr_done, mem_err, illegal_op;
  } outv_t;

  outv_t act_v;
  assign act_v = {PCout, ZLowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPC, Read,
                  ZLowIn, ZHighIn, HIin, LOin, r_out, r_in, operation, busy, instr_done, mem_err,
                  illegal_op};

  datapath_control_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .OPW(OPW)) dut (
    .clk(clk), .clr(clr), .run(run), .mem_ack(mem_ack),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .ir(ir),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC),
    .Read(Read), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
    .r_out(r_out), .r_in(r_in), .operation(operation), .busy(busy),
    .instr_done(instr_done), .mem_err(mem_err), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_err    = 0;
  int    n_cyc    = 0;
  bit    err_m    = 1'b0;
  bit    idle_m   = 1'b1;
  outv_t exp_v[$];
  int    exp_i[$];
  string exp_t[$];
  outv_t seen[int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Single compare process: every cycle with a queued expectation is checked at the falling edge.
  initial begin
    outv_t e;
    int    idx;
    string t;
    forever begin
      @(negedge clk);
      if (exp_v.size() != 0) begin
        e   = exp_v.pop_front();
        idx = exp_i.pop_front();
        t   = exp_t.pop_front();
        seen[idx] = act_v;
        check(t, 64'(act_v), 64'(e));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout expected=finish");
    $fatal(1);
  end

  function automatic outv_t base();
    outv_t v = '0;
    v.busy    = 1'b1;
    v.mem_err = err_m;
    return v;
  endfunction

  task automatic cyc(input outv_t v, input logic r, input logic a, input string tag);
    @(posedge clk);
    #1;
    run     = r;
    mem_ack = a;
    ir      = ir_next;
    exp_v.push_back(v);
    exp_i.push_back(n_cyc);
    exp_t.push_back(tag);
    n_cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    outv_t v;
    for (int i = 0; i < n; i++) begin
      v = base();
      v.busy = 1'b0;
      cyc(v, 1'b0, 1'b0, "idle");
    end
  endtask

  task automatic finish_instr(input logic run_tail, input string tag);
`ifdef SEQ_SINGLE_STEP_EN
    cyc(base(), run_tail, 1'b0, {tag, ".hold"});
`endif
    idle_m = !run_tail;
  endtask

  // Instruction-level model: ack_at = T1 cycle carrying mem_ack (0 = never), run_tail = run from T2 on.
  task automatic do_instr(input logic [31:0] iv, input int ack_at, input logic run_tail,
                          input bit clr_t4, input string tag, output int s);
    logic [4:0] op;
    int         ra, rb, rc;
    bit         alu, md, acked;
    outv_t      v;
    op  = iv[31:27];
    ra  = int'(iv[26:23]);
    rb  = int'(iv[22:19]);
    rc  = int'(iv[18:15]);
    alu = (op >= 5'h03) && (op <= 5'h0C);
    md  = (op == 5'h0F) || (op == 5'h10);
    ir_next = iv;
    if (idle_m) begin
      v = base();
      v.busy = 1'b0;
      cyc(v, 1'b1, 1'b0, {tag, ".idle"});
      idle_m = 1'b0;
    end
    s = n_cyc;
    v = base(); v.PCout = 1'b1; v.MARin = 1'b1; v.IncPC = 1'b1;
    cyc(v, 1'b1, 1'b0, {tag, ".t0"});
    acked = 1'b0;
    for (int k = 1; k <= MEM_TIMEOUT; k++) begin
      v = base(); v.Read = 1'b1; v.MDRin = 1'b1;
      cyc(v, 1'b1, (k == ack_at), $sformatf("%s.t1_%0d", tag, k));
      if (k == ack_at) begin
        acked = 1'b1;
        break;
      end
    end
    if (!acked) begin
      err_m  = 1'b1;
      idle_m = 1'b1;
      return;
    end
    v = base(); v.MDRout = 1'b1; v.IRin = 1'b1;
    cyc(v, run_tail, 1'b0, {tag, ".t2"});
    v = base();
    if (alu) begin
      v.r_out = 16'd1 << rb; v.Yin = 1'b1;
    end else if (md) begin
      v.r_out = 16'd1 << ra; v.Yin = 1'b1;
    end else begin
      v.illegal_op = 1'b1;
    end
    cyc(v, run_tail, 1'b0, {tag, ".t3"});
    if (!alu && !md) begin
      finish_instr(run_tail, tag);
      return;
    end
    v = base(); v.operation = op; v.ZLowIn = 1'b1; v.ZHighIn = 1'b1;
    v.r_out = 16'd1 << (alu ? rc : rb);
    cyc(v, run_tail, 1'b0, {tag, ".t4"});
    if (clr_t4) begin
      @(negedge clk);
      #1;
      clr = 1'b1;
      run = 1'b0;
      #1;
      check({tag, ".clr_outputs"}, 64'(act_v), 64'h0);
      err_m  = 1'b0;
      idle_m = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      return;
    end
    v = base(); v.ZLowout = 1'b1;
    if (alu) begin
      if (ra != 0) v.r_in = 16'd1 << ra;
      v.instr_done = 1'b1;
    end else begin
      v.LOin = 1'b1;
    end
    cyc(v, run_tail, 1'b0, {tag, ".t5"});
    if (alu) begin
      finish_instr(run_tail, tag);
      return;
    end
    v = base(); v.ZHighout = 1'b1; v.HIin = 1'b1; v.instr_done = 1'b1;
    cyc(v, run_tail, 1'b0, {tag, ".t6"});
    finish_instr(run_tail, tag);
  endtask

  initial begin
    int s, s_ill, i0;
    clr = 1'b1; run = 1'b0; mem_ack = 1'b0; ir = '0; ir_next = '0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b1;
`endif
    #12;
    check("reset_outputs", 64'(act_v), 64'h0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    idle_cycles(2);

    // ADD r1 <- r4 op r6, ack on first T1 cycle
    do_instr(32'h18A30000, 1, 1'b1, 1'b0, "add", s);
    settle();
    check("add_t3_rout", 64'(seen[s+3].r_out), 64'h0010);
    check("add_t4_rout", 64'(seen[s+4].r_out), 64'h0040);
    check("add_t4_op",   64'(seen[s+4].operation), 64'h03);
    check("add_t5_rin",  64'(seen[s+5].r_in), 64'h0002);
    check("add_t5_zlo",  64'(seen[s+5].ZLowout), 64'h1);
    check("add_c6_done", 64'(seen[s+5].instr_done), 64'h1);
    check("add_c5_nodone", 64'(seen[s+4].instr_done), 64'h0);

    // MUL ra=6 rb=7
    do_instr(32'h7B380000, 1, 1'b1, 1'b0, "mul", s);
    settle();
    check("mul_t3_rout", 64'(seen[s+3].r_out), 64'h0040);
    check("mul_t4_rout", 64'(seen[s+4].r_out), 64'h0080);
    check("mul_t4_op",   64'(seen[s+4].operation), 64'h0F);
    check("mul_t5_lo",   64'(seen[s+5].LOin), 64'h1);
    check("mul_t5_nodone", 64'(seen[s+5].instr_done), 64'h0);
    check("mul_t6_hi",   64'(seen[s+6].HIin), 64'h1);
    check("mul_t6_done", 64'(seen[s+6].instr_done), 64'h1);

    // Undecoded opcode 0x1F, then DIV with a 3-cycle memory wait
    do_instr(32'hF9A30000, 1, 1'b1, 1'b0, "ill1f", s_ill);
    do_instr(32'h84D00000, 3, 1'b1, 1'b0, "div", s);
    settle();
    check("ill_t3_pulse", 64'(seen[s_ill+3].illegal_op), 64'h1);
    check("ill_t3_noyin", 64'(seen[s_ill+3].Yin), 64'h0);
`ifdef SEQ_SINGLE_STEP_EN
    check("ill_refetch", 64'(seen[s_ill+5].PCout), 64'h1);
`else
    check("ill_refetch", 64'(seen[s_ill+4].PCout), 64'h1);
`endif
    check("div_t4_op",   64'(seen[s+6].operation), 64'h10);
    check("div_t6_done", 64'(seen[s+8].instr_done), 64'h1);

    // Opcode boundaries and a discarded R0 write
    do_instr(32'h67878000, 1, 1'b1, 1'b0, "alu0c", s);
    do_instr(32'h10000000, 1, 1'b1, 1'b0, "ill02", s);
    do_instr(32'h68000000, 2, 1'b1, 1'b0, "ill0d", s);
    do_instr(32'h88000000, 1, 1'b1, 1'b0, "ill11", s);
    do_instr(32'h51AC8000, 1, 1'b1, 1'b0, "alu0a", s);
    do_instr(32'h28118000, 1, 1'b1, 1'b0, "ra0", s);
    settle();
    check("ra0_rin",  64'(seen[s+5].r_in), 64'h0);
    check("ra0_done", 64'(seen[s+5].instr_done), 64'h1);

    // run dropped from T2: instruction completes, then IDLE
    do_instr(32'h18A30000, 2, 1'b0, 1'b0, "rundrop", s);
    i0 = n_cyc;
    idle_cycles(3);
    settle();
    check("rundrop_done", 64'(seen[s+6].instr_done), 64'h1);
    check("rundrop_idle", 64'(seen[i0+1].busy), 64'h0);

    // ack on the 15th T1 cycle still fetches; then a full timeout
    do_instr(32'h211A0000, 15, 1'b1, 1'b0, "ack15", s);
    settle();
    check("ack15_t2",  64'(seen[s+16].MDRout), 64'h1);
    check("ack15_err", 64'(seen[s+16].mem_err), 64'h0);
    do_instr(32'h18A30000, 0, 1'b1, 1'b0, "tmo", s);
    i0 = n_cyc;
    idle_cycles(2);
    settle();
    check("tmo_last_t1", 64'(seen[s+15].Read), 64'h1);
    check("tmo_err_set", 64'(seen[i0].mem_err), 64'h1);
    check("tmo_idle",    64'(seen[i0].busy), 64'h0);
    do_instr(32'h18A30000, 1, 1'b0, 1'b0, "posterr", s);
    idle_cycles(1);

    // clr mid-T4, then a clean restart
    do_instr(32'h18A30000, 1, 1'b1, 1'b1, "clr", s);
    do_instr(32'h18A30000, 1, 1'b0, 1'b0, "afterclr", s);
    idle_cycles(2);
    settle();
    check("afterclr_t0",  64'(seen[s].PCout), 64'h1);
    check("afterclr_err", 64'(seen[s].mem_err), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
